// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bus of the unified-memory port arbiter.
// slave is the arbiter's view; master is the view of the core stages and memory model.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DW-1:0]     if_rdata;

    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_be;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DW-1:0]     d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_be;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;

    logic              err;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rvalid, mem_rdata,
        output err
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rvalid, mem_rdata,
        input  err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data requesters.
// Data has priority, bounded by a streak limit so fetch cannot starve; a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk_signal,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int BW = DW / 8;
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } mem_cmd_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   streak, streak_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic            gnt_d, gnt_i, in_wait, rsp, abort, done;

    mem_cmd_t        cmd_q, cmd_nxt;
    logic            if_gnt_q, d_gnt_q, mem_req_q, err_q;
    logic            if_rvalid_q, d_rvalid_q;
    logic            if_gnt_nxt, d_gnt_nxt, mem_req_nxt, err_nxt;
    logic            if_rvalid_nxt, d_rvalid_nxt;
    logic [DW-1:0]   if_rdata_q, d_rdata_q, if_rdata_nxt, d_rdata_nxt;

    // State register
    always_ff @(posedge clk_signal or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            streak <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
            tcnt   <= tcnt_nxt;
        end
    end

    // Arbitration and next state
    always_comb begin
        in_wait = (state != IDLE);
        gnt_d   = !in_wait && bus.d_req &&
                  !(bus.if_req && (streak == SW'(MAX_D_STREAK)));
        gnt_i   = !in_wait && !gnt_d && bus.if_req;
        rsp     = in_wait && bus.mem_rvalid;
        // A response arriving on the last allowed cycle beats the watchdog.
        abort   = in_wait && !bus.mem_rvalid && (tcnt == TW'(TIMEOUT - 1));
        done    = rsp || abort;

        state_nxt  = state;
        streak_nxt = streak;
        tcnt_nxt   = tcnt;
        case (state)
            IDLE: begin
                if (gnt_d) begin
                    state_nxt  = WAIT_D;
                    streak_nxt = bus.if_req ? streak + SW'(1) : '0;
                    tcnt_nxt   = '0;
                end else if (gnt_i) begin
                    state_nxt  = WAIT_I;
                    streak_nxt = '0;
                    tcnt_nxt   = '0;
                end
            end
            WAIT_I, WAIT_D: begin
                tcnt_nxt = tcnt + TW'(1);
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        if_gnt_nxt    = gnt_i;
        d_gnt_nxt     = gnt_d;
        mem_req_nxt   = gnt_i || gnt_d;
        err_nxt       = abort;
        if_rvalid_nxt = done && (state == WAIT_I);
        d_rvalid_nxt  = done && (state == WAIT_D);

        cmd_nxt = cmd_q;
        if (gnt_d) begin
            cmd_nxt.we    = bus.d_we;
            cmd_nxt.addr  = bus.d_addr;
            cmd_nxt.wdata = bus.d_wdata;
            cmd_nxt.be    = bus.d_be;
        end else if (gnt_i) begin
            cmd_nxt.we    = 1'b0;
            cmd_nxt.addr  = bus.if_addr;
            cmd_nxt.wdata = '0;
            cmd_nxt.be    = '1;
        end

        // rdata holds between pulses; aborts and store acks return zero.
        if_rdata_nxt = if_rdata_q;
        if (if_rvalid_nxt)
            if_rdata_nxt = rsp ? bus.mem_rdata : '0;
        d_rdata_nxt = d_rdata_q;
        if (d_rvalid_nxt)
            d_rdata_nxt = (rsp && !cmd_q.we) ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk_signal or negedge reset) begin
        if (!reset) begin
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            cmd_q       <= '0;
        end else begin
            if_gnt_q    <= if_gnt_nxt;
            d_gnt_q     <= d_gnt_nxt;
            mem_req_q   <= mem_req_nxt;
            err_q       <= err_nxt;
            if_rvalid_q <= if_rvalid_nxt;
            d_rvalid_q  <= d_rvalid_nxt;
            if_rdata_q  <= if_rdata_nxt;
            d_rdata_q   <= d_rdata_nxt;
            cmd_q       <= cmd_nxt;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.mem_be    = cmd_q.be;
    assign bus.err       = err_q;
endmodule
